// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types used by the issue stage and its scoreboard.
package riscv_pkg;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        logic [6:0] funct7;
        reg_idx_t   rs2;
        reg_idx_t   rs1;
        logic [2:0] funct3;
        reg_idx_t   rd;
        logic [6:0] opcode;
    } instruction_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/pending_table.sv
// Pending-write scoreboard: one bit per register, set-over-clear, x0 never set.
// WB_BYPASS_EN: effective vector also hides a bit being retired this cycle.
module pending_table
    import riscv_pkg::*;
#(
    parameter  int NREGS = 32,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    output logic [NREGS-1:0] pending,
    output logic [NREGS-1:0] eff
);

    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && set_idx != '0)
            set_mask = NREGS'(1) << set_idx;
        if (clr_en && clr_idx != '0)
            clr_mask = NREGS'(1) << clr_idx;
    end

    // A newer producer issuing into the register being retired must stay pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= '0;
        else
            pending <= (pending & ~clr_mask) | set_mask;
    end

`ifdef WB_BYPASS_EN
    assign eff = pending & ~clr_mask;
`else
    assign eff = pending;
`endif

endmodule

// File: rtl/issue_scoreboard.sv
// Single-entry issue stage that stalls on RAW/WAW hazards against pending writes.
// WB_BYPASS_EN: lets a stalled instruction issue in the cycle its writeback lands.
module issue_scoreboard
    import riscv_pkg::*;
#(
    parameter  int NREGS       = 32,
    parameter  int STALL_CNT_W = 32,
    localparam int IDX_W       = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  instruction_t           in_instr,
    input  logic                   in_uses_rs1,
    input  logic                   in_uses_rs2,
    input  logic                   in_writes_rd,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output instruction_t           issue_instr,
    input  logic                   wb_valid,
    input  logic [IDX_W-1:0]       wb_rd,
    input  logic                   flush,
    output logic [NREGS-1:0]       pending,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_HELD  = 1'b1;

    logic             state;
    instruction_t     held;
    logic             held_rs1;
    logic             held_rs2;
    logic             held_wr;
    logic [NREGS-1:0] p_eff;
    logic             hazard;
    logic             fire;
    logic             accept;

    assign hazard = (held_rs1 && held.rs1 != REG_ZERO && p_eff[held.rs1])
                 || (held_rs2 && held.rs2 != REG_ZERO && p_eff[held.rs2])
                 || (held_wr  && held.rd  != REG_ZERO && p_eff[held.rd]);

    assign issue_valid = (state == ST_HELD) && !hazard && !flush;
    assign fire        = issue_valid && issue_ready;
    assign in_ready    = !flush && (state == ST_EMPTY || fire);
    assign accept      = in_valid && in_ready;
    assign issue_instr = held;

    // Flush drops only the held slot; in-flight producers still own their pending bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            held     <= '0;
            held_rs1 <= 1'b0;
            held_rs2 <= 1'b0;
            held_wr  <= 1'b0;
        end else if (flush) begin
            state <= ST_EMPTY;
        end else if (accept) begin
            state    <= ST_HELD;
            held     <= in_instr;
            held_rs1 <= in_uses_rs1;
            held_rs2 <= in_uses_rs2;
            held_wr  <= in_writes_rd;
        end else if (fire) begin
            state <= ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (state == ST_HELD && hazard && !flush && stall_cycles != '1)
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end

    pending_table #(.NREGS(NREGS)) u_pending (
        .clk     (clk),
        .rst     (rst),
        .set_en  (fire && held_wr),
        .set_idx (IDX_W'(held.rd)),
        .clr_en  (wb_valid),
        .clr_idx (wb_rd),
        .pending (pending),
        .eff     (p_eff)
    );

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard; honours WB_BYPASS_EN when defined.
module tb_issue_scoreboard;
    import riscv_pkg::*;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid, in_ready, in_uses_rs1, in_uses_rs2, in_writes_rd;
    instruction_t in_instr, issue_instr;
    logic         issue_valid, issue_ready, wb_valid, flush;
    logic [4:0]   wb_rd;
    logic [31:0]  pending, stall_cycles;

    int checks = 0;
    int errors = 0;
    instruction_t exp_q[$];

    typedef struct {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic        u1;
        logic        wr;
        logic [31:0] exp_pend;
    } vec_t;

    issue_scoreboard dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .in_writes_rd(in_writes_rd),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .pending(pending), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic instruction_t mk(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3);
        instruction_t i;
        i        = '0;
        i.opcode = 7'h33;
        i.rd     = rd;
        i.rs1    = rs1;
        i.rs2    = rs2;
        i.funct3 = f3;
        return i;
    endfunction

    task automatic drive(input instruction_t i, input logic u1, input logic u2, input logic wr);
        in_valid     = 1'b1;
        in_instr     = i;
        in_uses_rs1  = u1;
        in_uses_rs2  = u2;
        in_writes_rd = wr;
    endtask

    task automatic idle();
        in_valid     = 1'b0;
        in_uses_rs1  = 1'b0;
        in_uses_rs2  = 1'b0;
        in_writes_rd = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: accepted instructions queue up and must come out in order on issue fire.
    always @(negedge clk) begin
        instruction_t e;
        if (!rst && issue_valid && issue_ready) begin
            if (exp_q.size() == 0) begin
                check("issue_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("issue_instr", issue_instr, e);
            end
        end
        if (!rst && in_valid && in_ready)
            exp_q.push_back(in_instr);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   n;
        vecs[0] = '{rd: 5'd1, rs1: 5'd0, u1: 1'b0, wr: 1'b1, exp_pend: 32'h0000_0002};
        vecs[1] = '{rd: 5'd2, rs1: 5'd0, u1: 1'b1, wr: 1'b1, exp_pend: 32'h0000_0006};
        vecs[2] = '{rd: 5'd3, rs1: 5'd0, u1: 1'b1, wr: 1'b1, exp_pend: 32'h0000_000E};
        vecs[3] = '{rd: 5'd0, rs1: 5'd0, u1: 1'b1, wr: 1'b1, exp_pend: 32'h0000_000E};
        n = 4;

        idle();
        in_instr    = '0;
        issue_ready = 1'b1;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        flush       = 1'b0;

        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_issue_valid", issue_valid, 0);
        check("rst_pending", pending, 0);
        check("rst_stall", stall_cycles, 0);
        check("rst_issue_instr", issue_instr, 0);
        tick();
        rst = 1'b0;

        // Back-to-back independent writers, then an x0 writer reading x0.
        for (int k = 0; k < n + 2; k++) begin
            if (k < n) drive(mk(vecs[k].rd, vecs[k].rs1, 5'd0, 3'd0), vecs[k].u1, 1'b0, vecs[k].wr);
            else idle();
            #1;
            check("b2b_issue_valid", issue_valid, (k >= 1 && k <= n));
            if (k >= 2) check("b2b_pending", pending, vecs[k-2].exp_pend);
            tick();
        end
        check("b2b_stall", stall_cycles, 0);

        for (int r = 0; r < 4; r++) begin
            wb_valid = 1'b1;
            wb_rd    = 5'(r);
            tick();
        end
        wb_rd = 5'd1;
        tick();
        wb_valid = 1'b0;
        #1 check("wb_clear_pending", pending, 0);
        tick();

        // RAW on x5, writeback arrives in the fourth held cycle.
        drive(mk(5'd5, 5'd0, 5'd0, 3'd1), 1'b0, 1'b0, 1'b1);
        tick();
        drive(mk(5'd0, 5'd5, 5'd0, 3'd2), 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        #1 check("raw_stall", issue_valid, 0);
        tick();
        tick();
        tick();
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        #1 check("raw_wb_cycle_issue", issue_valid, BYP);
        tick();
        wb_valid = 1'b0;
        #1 check("raw_late_issue", issue_valid, !BYP);
        tick();
        check("raw_stall_cnt", stall_cycles, BYP ? 3 : 4);
        check("raw_pending", pending, 0);

        // WAW on x7.
        drive(mk(5'd7, 5'd0, 5'd0, 3'd3), 1'b0, 1'b0, 1'b1);
        tick();
        drive(mk(5'd7, 5'd0, 5'd0, 3'd4), 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        #1 check("waw_stall", issue_valid, 0);
        check("waw_p7_set", pending[7], 1);
        tick();
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        #1 check("waw_wb_cycle_issue", issue_valid, BYP);
        tick();
        wb_valid = 1'b0;
        #1 check("waw_late_issue", issue_valid, !BYP);
        tick();
        check("waw_p7_again", pending, 32'h0000_0080);
        check("waw_stall_cnt", stall_cycles, BYP ? 4 : 6);

        // Same-edge set and clear of x9: set must win.
        drive(mk(5'd9, 5'd0, 5'd0, 3'd5), 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        wb_valid = 1'b1;
        wb_rd    = 5'd9;
        #1 check("sc_issue", issue_valid, 1);
        tick();
        wb_valid = 1'b0;
        #1 check("sc_p9_set_wins", pending, 32'h0000_0280);
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        tick();
        wb_rd = 5'd9;
        tick();
        wb_valid = 1'b0;
        #1 check("sc_cleared", pending, 0);
        tick();

        // Stall on rs2=x4, flush it while another instruction is offered.
        drive(mk(5'd4, 5'd0, 5'd0, 3'd6), 1'b0, 1'b0, 1'b1);
        tick();
        drive(mk(5'd0, 5'd0, 5'd4, 3'd7), 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        #1 check("fl_stall", issue_valid, 0);
        tick();
        flush = 1'b1;
        drive(mk(5'd3, 5'd0, 5'd0, 3'd0), 1'b0, 1'b0, 1'b1);
        #1 check("fl_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        idle();
        exp_q.delete();
        #1 check("fl_empty", in_ready, 1);
        check("fl_p4", pending, 32'h0000_0010);
        check("fl_stall_cnt", stall_cycles, BYP ? 5 : 7);

        // Re-stall, then assert reset in the middle of a cycle.
        drive(mk(5'd0, 5'd0, 5'd4, 3'd7), 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        #1 rst = 1'b1;
        #1;
        check("arst_pending", pending, 0);
        check("arst_stall", stall_cycles, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_issue_valid", issue_valid, 0);
        check("arst_issue_instr", issue_instr, 0);
        tick();
        rst = 1'b0;
        exp_q.delete();

        // One-cycle accept-to-issue after reset.
        drive(mk(5'd2, 5'd0, 5'd0, 3'd1), 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        #1 check("post_rst_issue", issue_valid, 1);
        tick();
        check("post_rst_pending", pending, 32'h0000_0004);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

- Single-entry issue stage between instruction decode and execute.
- Holds one decoded instruction and tracks outstanding register writes in a 32-entry pending-write scoreboard.
- Stalls issue on RAW or WAW hazards until writeback retires the producing instruction.
- Provides the only flow control between decode and the execute/writeback path.

## Interface
- NREGS, default 32: number of architectural registers; index width is $clog2(NREGS).
- STALL_CNT_W, default 32: width of the saturating stall-cycle counter.
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  decode offers an instruction.
- in_ready  output  1  the holding register can accept this cycle.
- in_instr  input  instruction_t  decoded fields (opcode, rd, rs1, rs2, funct3, funct7).
- in_uses_rs1, in_uses_rs2, in_writes_rd  input  1 each  operand and destination usage flags.
- issue_valid  output  1  the held instruction is hazard-free and is presented to execute.
- issue_ready  input  1  execute accepts.
- issue_instr  output  instruction_t  the held instruction, stable while issue_valid && !issue_ready.
- wb_valid  input  1  writeback retires a register write.
- wb_rd  input  $clog2(NREGS)  register being written back.
- flush  input  1  discard the held instruction (branch redirect).
- pending  output  NREGS  current scoreboard bits, for debug.
- stall_cycles  output  STALL_CNT_W  saturating count of hazard-stall cycles.

## Operation
- FSM states:
  - EMPTY: nothing held.
  - HELD: holding register valid.
- Transitions:
  - EMPTY→HELD on accept (in_valid && in_ready).
  - HELD→EMPTY on issue fire (issue_valid && issue_ready) with no simultaneous accept.
  - HELD→HELD on fire plus accept (back-to-back).
  - Any state→EMPTY on flush.
- in_ready = !flush && (state==EMPTY || issue fire).
- Hazard = (uses_rs1 && rs1!=0 && P[rs1]) || (uses_rs2 && rs2!=0 && P[rs2]) || (writes_rd && rd!=0 && P[rd]).
  - P is the effective pending vector (see Configuration).
- issue_valid = state==HELD && !hazard && !flush.
- Scoreboard update each edge:
  - A wb_valid write clears bit wb_rd.
  - An issue fire with writes_rd && rd!=0 sets bit rd.
  - If both target the same register in one cycle, the set wins (newer producer).
- Register 0 is never set; wb_rd==0 is ignored.
- flush clears only the holding register. Pending bits are untouched, because in-flight instructions still write back.
- stall_cycles increments each cycle state==HELD && hazard && !flush. It saturates at all-ones.
- wb_valid for a register whose bit is already clear is legal and has no effect.

## Timing
- Reset values:
  - state=EMPTY, in_ready=1, issue_valid=0.
  - issue_instr=0, pending=0, stall_cycles=0.
- Accept-to-issue latency: 1 cycle. An instruction accepted at edge N is visible on issue_valid in cycle N+1 if hazard-free.
- Throughput: one instruction per cycle when hazard-free and issue_ready is held high.
- Stall release latency is set by Configuration.
- in_ready is combinational from issue_ready and flush. No other outputs depend combinationally on in_* inputs.
- Flush priority: flush beats accept and issue in the same cycle.
- Reset mid-operation discards the held instruction and all pending bits immediately; no outputs glitch high.

## Configuration
- WB_BYPASS_EN defined:
  - P = pending & ~(wb_valid ? onehot(wb_rd) : 0).
  - A stalled instruction issues in the same cycle its blocking writeback arrives.
- WB_BYPASS_EN undefined:
  - P = pending.
  - Issue occurs at the earliest one cycle after the writeback. This removes the wb→issue_valid combinational path.

## Structure
- Shared package riscv_pkg:
  - instruction_t, which already exists.
  - An added reg_idx_t typedef.
  - Constant REG_ZERO = 0.
- Sub-module pending_table:
  - Holds the NREGS-bit scoreboard with set/clear ports.
  - Implements set-over-clear priority, x0 masking, and the optional bypass mask.
  - Outputs P.
- The FSM, holding register and stall counter stay in issue_scoreboard.

## Test plan
- Back-to-back independent adds (rd=1,2,3; rs1=rs2=0), issue_ready=1.
  - Required: three issues on consecutive cycles.
  - Required: pending=0x0000000E after the last issue; stall_cycles=0.
- RAW: issue rd=5, then rs1=5, with wb_valid rd=5 three cycles later.
  - Required: second instruction stalls, and stall_cycles counts 3 (bypass) or 4 (no bypass).
  - Required: it issues in the wb cycle (bypass) or the cycle after (no bypass).
- WAW: held instruction writes rd=7 while P[7]=1.
  - Required: stall until wb_rd=7.
  - Required: after issue, P[7]=1 again.
- Same-cycle set/clear on rd=9 (issue writes 9, wb_rd=9).
  - Required: P[9]=1 afterward.
- x0 handling: writes_rd with rd=0, and wb_rd=0.
  - Required: pending stays 0; rs1=0 never stalls.
- Flush while stalled on rs2=4, then rst asserted mid-stall.
  - Required: flush gives state EMPTY next cycle and P[4] unchanged.
  - Required: rst clears pending and stall_cycles asynchronously; in_ready=1.
